// File: rtl/card_shoe.sv
// ============================================================================
// Module   : card_shoe
// Purpose  : Multi-deck card shoe with LFSR-driven in-place Fisher-Yates
//            shuffle and a ready/request deal port with card decode.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module card_shoe #(
    parameter  int          DECKS        = 1,
    parameter  logic [15:0] SEED         = 16'hACE1,
    parameter  int          RESHUFFLE_AT = 15,
    localparam int          N            = 52 * DECKS,
    localparam int          IW           = $clog2(N)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          shuffle_req,
    input  logic          draw_req,
    output logic          ready,
    output logic          shuffling,
    output logic          card_valid,
    output logic [5:0]    card_id,
    output logic [3:0]    card_rank,
    output logic [1:0]    card_suit,
    output logic [3:0]    card_value,
    output logic [IW:0]   remaining,
    output logic          reshuffle_due
);

    localparam logic [15:0]   LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0]   LFSR_TAPS = 16'hB400;
    localparam logic [IW-1:0] LAST      = IW'(N - 1);
    localparam logic [IW:0]   FULL      = (IW + 1)'(N);
    localparam logic [IW:0]   DUE_LEVEL = (IW + 1)'(RESHUFFLE_AT);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_PICK = 2'd1,
        S_SWAP = 2'd2,
        S_DEAL = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      mem_q [N];
    logic [IW-1:0]   i_q, i_d, j_q, j_d, ptr_q, ptr_d, cnt_q, cnt_d;
    logic [IW:0]     rem_q, rem_d;
    logic [5:0]      init_id_q, init_id_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic            shuf_q;
    logic            valid_q, valid_d;
    logic [5:0]      cid_q, cid_d;
    logic [3:0]      rank_q, rank_d, value_q, value_d;
    logic [1:0]      suit_q, suit_d;

    logic [5:0]      w_id, w_base;
    logic [1:0]      w_suit;
    logic [3:0]      w_rank, w_value;
    logic [IW-1:0]   w_cand;
    logic [15:0]     w_lfsr_next;

    assign w_cand      = lfsr_q[IW-1:0];
    assign w_lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    assign w_id        = mem_q[ptr_q];

    // Card decode of the id at the deal pointer: suit = id/13, rank = id%13+1
    always_comb begin
        w_suit = 2'd0;
        w_base = 6'd0;
        if (w_id >= 6'd39) begin
            w_suit = 2'd3;
            w_base = 6'd39;
        end else if (w_id >= 6'd26) begin
            w_suit = 2'd2;
            w_base = 6'd26;
        end else if (w_id >= 6'd13) begin
            w_suit = 2'd1;
            w_base = 6'd13;
        end
        w_rank  = 4'(w_id - w_base) + 4'd1;
        w_value = (w_rank > 4'd10) ? 4'd10 : w_rank;
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        init_id_d = init_id_q;
        lfsr_d    = lfsr_q;
        valid_d   = 1'b0;
        cid_d     = cid_q;
        rank_d    = rank_q;
        suit_d    = suit_q;
        value_d   = value_q;
        case (state_q)
            S_INIT: begin
                if (cnt_q == LAST) begin
                    i_d     = LAST;
                    state_d = S_PICK;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    init_id_d = (init_id_q == 6'd51) ? 6'd0 : init_id_q + 6'd1;
                end
            end
            S_PICK: begin
                lfsr_d = w_lfsr_next;
                if (w_cand <= i_q) begin
                    j_d     = w_cand;
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                if (i_q == IW'(1)) begin
                    ptr_d   = '0;
                    rem_d   = FULL;
                    state_d = S_DEAL;
                end else begin
                    i_d     = i_q - 1'b1;
                    state_d = S_PICK;
                end
            end
            S_DEAL: begin
                // Shuffle beats a simultaneous draw; an empty-shoe draw reshuffles
                if (shuffle_req) begin
                    i_d     = LAST;
                    state_d = S_PICK;
                end else if (draw_req) begin
                    if (rem_q != '0) begin
                        valid_d = 1'b1;
                        cid_d   = w_id;
                        rank_d  = w_rank;
                        suit_d  = w_suit;
                        value_d = w_value;
                        ptr_d   = ptr_q + 1'b1;
                        rem_d   = rem_q - 1'b1;
                    end else begin
                        i_d     = LAST;
                        state_d = S_PICK;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= S_INIT;
            i_q       <= '0;
            j_q       <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            rem_q     <= '0;
            init_id_q <= '0;
            lfsr_q    <= LFSR_INIT;
            shuf_q    <= 1'b0;
            valid_q   <= 1'b0;
            cid_q     <= '0;
            rank_q    <= '0;
            suit_q    <= '0;
            value_q   <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            init_id_q <= init_id_d;
            lfsr_q    <= lfsr_d;
            shuf_q    <= (state_d != S_DEAL);
            valid_q   <= valid_d;
            cid_q     <= cid_d;
            rank_q    <= rank_d;
            suit_q    <= suit_d;
            value_q   <= value_d;
        end
    end

    // Card storage is not cleared on reset; INIT rewrites every entry
    always_ff @(posedge clock) begin
        if (resetn) begin
            if (state_q == S_INIT) begin
                mem_q[cnt_q] <= init_id_q;
            end else if (state_q == S_SWAP) begin
                mem_q[i_q] <= mem_q[j_q];
                mem_q[j_q] <= mem_q[i_q];
            end
        end
    end

    assign ready         = (state_q == S_DEAL);
    assign shuffling     = shuf_q;
    assign card_valid    = valid_q;
    assign card_id       = cid_q;
    assign card_rank     = rank_q;
    assign card_suit     = suit_q;
    assign card_value    = value_q;
    assign remaining     = rem_q;
    assign reshuffle_due = ready && (rem_q <= DUE_LEVEL);

endmodule

`default_nettype wire

// File: doc/card_shoe.md
# card_shoe

Parametrised multi-deck card shoe for the blackjack datapath: holds DECKS×52 card ids, shuffles them in place with a seeded LFSR-driven Fisher-Yates pass, and deals one card per accepted request with rank, suit and blackjack value decoded. It replaces the fixed-table card source. The round-control FSM draws through a ready/request handshake and uses `reshuffle_due` to schedule shuffles between rounds.

## Interface
- DECKS, 1: number of 52-card decks; N = 52·DECKS; IW = clog2(N).
- SEED, 16'hACE1: LFSR reset value; 0 is replaced by 16'h0001.
- RESHUFFLE_AT, 15: `reshuffle_due` is asserted while remaining ≤ RESHUFFLE_AT.
- clock  in  1  sole clock; all logic is on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- shuffle_req  in  1  start an in-place reshuffle; honoured only when ready=1.
- draw_req  in  1  request one card; accepted when ready=1 and remaining>0.
- ready  out  1  in DEAL state; draws and shuffle requests are accepted.
- shuffling  out  1  in INIT, PICK or SWAP.
- card_valid  out  1  one-cycle pulse; card fields are valid.
- card_id  out  6  0..51; suit = id/13, rank = id%13 + 1.
- card_rank  out  4  1..13 (A=1, J=11, Q=12, K=13).
- card_suit  out  2  0..3.
- card_value  out  4  min(rank,10); ace reported as 1.
- remaining  out  IW+1  undealt cards.
- reshuffle_due  out  1  remaining ≤ RESHUFFLE_AT.

## Operation
- Storage: N-entry register file of 6-bit ids.
- Pointers: `ptr` (next card) and `i` (shuffle index).
- LFSR: 16-bit Galois, taps 16'hB400. Advances only in PICK. It is not reloaded by `shuffle_req`, so successive shuffles differ. It is reloaded with SEED only on reset.
- FSM states:
  - INIT: write mem[k] = k mod 52 for k = 0..N-1, one entry per cycle. Then i ← N-1 and go to PICK.
  - PICK: candidate c = lfsr[IW-1:0]. If c ≤ i, latch j ← c and go to SWAP. Otherwise advance the LFSR and stay in PICK. The LFSR also advances on the accepting cycle.
  - SWAP: exchange mem[i] and mem[j] in one cycle. If i == 1, set ptr ← 0, remaining ← N and go to DEAL. Otherwise i ← i-1 and go to PICK.
  - DEAL:
    - Accepted draw: register mem[ptr] into the card outputs, ptr ← ptr+1, remaining ← remaining-1.
    - `shuffle_req`: i ← N-1, go to PICK. There is no refill; the array is still a permutation of the multiset.
    - draw_req with remaining = 0: the draw is not accepted. The block goes to PICK (auto-reshuffle) and no card_valid is produced.
- Priority: `shuffle_req` and `draw_req` in the same DEAL cycle → the shuffle wins and the draw is dropped (no card_valid).
- Requests while ready=0 are ignored; they are not queued.
- DECKS=1 with i reaching 0 cannot occur, because N ≥ 52.
- Card fields hold their last dealt value until the next accepted draw.
- Reset values: ready=0, shuffling=0, card_valid=0, card_id/rank/suit/value=0, remaining=0, reshuffle_due=0, ptr=0, FSM=INIT, lfsr=SEED (or 1 if SEED is 0).

## Timing
- INIT takes exactly N cycles; `shuffling`=1 from the first cycle after resetn rises.
- Each swap costs (PICK cycles) + 1. PICK length is data-dependent but deterministic for a given SEED.
- `ready` rises on the cycle after the final SWAP. `ready` and `shuffling` are never both 1.
- Draw latency: draw_req accepted at edge t → card_valid=1 and card fields valid during cycle t+1.
- Back-to-back draws are accepted every cycle; `remaining` decrements on the accepting edge.
- `reshuffle_due` is combinational from `remaining`. It is forced to 0 while `shuffling`=1.
- resetn low at any edge, including mid-INIT, mid-PICK or mid-SWAP: all state returns to reset values on that edge, with no partial swap retained.

## Test plan
- DECKS=1, reset, wait for ready, then assert draw_req for 52 cycles → 52 card_valid pulses; ids are a permutation of 0..51; remaining steps 51→0; every card satisfies value = min(id%13+1, 10) and suit = id/13.
- Same SEED, two separate resets, 52 draws each → identical id sequences. Then issue shuffle_req, wait for ready, draw 52 → sequence differs from the first and is still a permutation.
- DECKS=2, RESHUFFLE_AT=15: draw 88 cards → reshuffle_due is 0 through remaining=16 and rises exactly when remaining becomes 15. Draw the remaining 16 → every id appears exactly twice over the 104 cards.
- DECKS=1, after 52 draws assert draw_req at remaining=0 → no card_valid; ready falls next cycle and shuffling=1; ready later returns with remaining=52.
- In DEAL with remaining=40, assert shuffle_req and draw_req in the same cycle → no card_valid, shuffle runs, remaining=52 when ready returns.
- Pull resetn low for one cycle mid-PICK → all outputs at reset values; INIT reruns for N cycles; the post-reset deal sequence equals the sequence from the first reset.
